// File: rtl/nibbler_io_pkg.sv
// -----------------------------------------------------------------------------
// nibbler_io_pkg
// Shared definitions for the nibble I/O responder: port address map, STATUS and
// CTRL bit positions, and the nibble type used on both the processor and the
// external side.
// -----------------------------------------------------------------------------
package nibbler_io_pkg;

    typedef logic [3:0] nibble_t;

    // Port address map seen by microcode.
    localparam logic [1:0] PORT_DATA   = 2'd0;
    localparam logic [1:0] PORT_STATUS = 2'd1;
    localparam logic [1:0] PORT_CTRL   = 2'd2;

    // STATUS register bit positions.
    localparam int ST_AVAIL  = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_TXBUSY = 2;
    localparam int ST_ERR    = 3;

    // CTRL register bit positions.
    localparam int CTRL_FLUSH  = 0;
    localparam int CTRL_CLRERR = 3;

endpackage

// File: rtl/nibble_io_port_fifo.sv
// -----------------------------------------------------------------------------
// nibble_fifo
// Synchronous push/pop FIFO of nibbles with occupancy count.
//   clk, reset : clock, asynchronous active-high reset
//   flush      : synchronous clear of count and pointers; wins over push/pop
//   push/wdata : write request and nibble; accepted when not full, or when a
//                pop frees a slot on the same edge
//   pop        : read request; ignored while empty
//   head       : nibble at the read pointer (undefined contents while empty)
//   count      : occupancy, 0..DEPTH
//   full/empty : occupancy flags
// -----------------------------------------------------------------------------
module nibble_fifo
    import nibbler_io_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  nibble_t                    wdata,
    output nibble_t                    head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

    nibble_t            mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // A pop on the same edge frees the slot a full-FIFO push needs.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: the storage array has no reset; count and pointers define what is
    // valid, so resetting the data would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nibble_io_port.sv
// -----------------------------------------------------------------------------
// nibble_io_port
// Memory-mapped 4-bit I/O responder on the processor databus.
//   clk, reset          : clock, asynchronous active-high reset
//   cs_n, we_n          : active-low chip select / write enable (RAM style)
//   port_addr, wdata    : register select (DATA/STATUS/CTRL/rsvd), write nibble
//   rdata, rdata_oe     : combinational read nibble and tristate enable
//   in_strobe, in_data  : external receive nibble source, no backpressure
//   out_valid, out_data : single-entry transmit holding register
//   out_ready           : sink accepts at an edge where out_valid=1
// -----------------------------------------------------------------------------
module nibble_io_port
    import nibbler_io_pkg::*;
#(
    parameter int RX_DEPTH = 4,
    parameter int RX_PTR_W = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs_n,
    input  logic       we_n,
    input  logic [1:0] port_addr,
    input  logic [3:0] wdata,
    output logic [3:0] rdata,
    output logic       rdata_oe,
    input  logic       in_strobe,
    input  logic [3:0] in_data,
    output logic       out_valid,
    output logic [3:0] out_data,
    input  logic       out_ready
);

    nibble_t           rx_head;
    logic [RX_PTR_W:0] rx_count;
    logic              rx_full;
    logic              rx_empty;
    logic              rx_pop;
    logic              rx_flush;
    logic              rx_overflow;

    logic              wr_en;
    logic              tx_write;
    logic              tx_accept;
    logic              tx_drop;
    logic              err;
    logic              err_set;
    logic              err_clr;

    // Bus decode.
    assign rdata_oe  = !cs_n && we_n;
    assign wr_en     = !cs_n && !we_n;
    assign rx_pop    = rdata_oe && (port_addr == PORT_DATA) && !rx_empty;
    assign rx_flush  = wr_en && (port_addr == PORT_CTRL) && wdata[CTRL_FLUSH];
    assign err_clr   = wr_en && (port_addr == PORT_CTRL) && wdata[CTRL_CLRERR];
    assign tx_write  = wr_en && (port_addr == PORT_DATA);

    // A write into a pending slot succeeds only if the sink drains it this edge.
    assign tx_accept = tx_write && (!out_valid || out_ready);
    assign tx_drop   = tx_write && out_valid && !out_ready;

    // Full FIFO loses the nibble unless a read makes room on the same edge.
    assign rx_overflow = in_strobe && rx_full && !rx_pop;
    assign err_set     = rx_overflow || tx_drop;

    nibble_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (rx_flush),
        .push  (in_strobe),
        .pop   (rx_pop),
        .wdata (in_data),
        .head  (rx_head),
        .count (rx_count),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // NOTE: rdata gets its default before the decode so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        rdata = '0;
        if (rdata_oe) begin
            case (port_addr)
                PORT_DATA: begin
                    rdata = rx_empty ? '0 : rx_head;
                end
                PORT_STATUS: begin
                    rdata[ST_AVAIL]  = (rx_count != '0);
                    rdata[ST_FULL]   = rx_full;
                    rdata[ST_TXBUSY] = out_valid;
                    rdata[ST_ERR]    = err;
                end
                default: rdata = '0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            err       <= 1'b0;
        end else begin
            if (tx_accept) begin
                out_data  <= wdata;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            // A new error on the clearing edge must not be lost.
            if (err_set) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule
